game_stats_ctrl: RTL and testbench
==================================

// Module: game_stats_ctrl
// PURPOSE
//  Upstream stage of the HEX/LED status display. Converts raw gameplay events
//  (enemy killed, player hit, start) into score, health and game-over state.
//  Emits the single-cycle pulses and final-score load the display stage consumes.
//  Runs a PLAY/GAME-OVER state machine, including timed game-over animation steps.
// PARAMETERS
//  START_HEALTH    4'hF        health loaded on game start
//  HIT_COOLDOWN    25_000_000  clk cycles of invulnerability after an accepted hit (>=1)
//  GO_STEP_CYCLES  12_500_000  clk cycles between game-over animation pulses (>=1)
//  GO_STEPS        4           number of gameover_pulse strobes before DONE (1..15)
// PORTS
//  clk            in   1  system clock, 50 MHz
//  reset          in   1  synchronous, active-high reset
//  start          in   1  level; sampled each cycle, acted on in IDLE/DONE only
//  enemy_killed   in   1  1-cycle pulse per kill
//  player_hit     in   1  1-cycle pulse per collision
//  score          out  8  current score
//  health         out  4  current health
//  score_pulse    out  1  1-cycle strobe per accepted kill
//  health_pulse   out  1  1-cycle strobe per accepted hit
//  gameover_pulse out  1  1-cycle strobe per animation step
//  final_score    out  8  score latched at game-over
//  final_valid    out  1  high while final_score holds a finished game's score
//  state          out  2  0 IDLE, 1 PLAY, 2 OVER, 3 DONE
// BEHAVIOUR
//  - All outputs registered. Every response appears 1 cycle after the sampling edge.
//  - Reset, which overrides all other inputs: state=IDLE, score=0, health=START_HEALTH,
//    final_score=0, final_valid=0, all pulses 0, cooldown and step counters 0.
//  - IDLE: kill and hit are ignored. start=1 -> PLAY, score<=0, health<=START_HEALTH,
//    cooldown<=0, final_valid<=0.
//  - PLAY, kill: score+1 and score_pulse=1. Score saturates at 8'hFF.
//    At saturation score_pulse still fires and score holds.
//  - PLAY, hit: accepted only when cooldown==0. On accept: health-1, health_pulse=1,
//    cooldown<=HIT_COOLDOWN-1. While cooldown!=0, cooldown decrements by 1 per cycle.
//    A hit arriving while cooldown!=0 is dropped, with no pulse.
//  - If an accepted hit makes health 0: next state OVER, final_score<=score (including
//    any kill counted in that same cycle), step counter and timer cleared.
//  - Kill and hit in the same cycle: both are applied, and both pulses fire together.
//  - start is ignored in PLAY and OVER.
//  - OVER: timer counts 0..GO_STEP_CYCLES-1. At wrap, gameover_pulse=1 and the step
//    count increments. After pulse number GO_STEPS -> DONE, final_valid<=1.
//    Kill and hit are ignored.
//  - DONE: all outputs hold. start=1 -> PLAY with the same initialisation as from IDLE,
//    final_valid<=0, final_score retained.
//  - Health never underflows. Health reaches 0 only via the PLAY -> OVER transition.
//  - Reset in mid-game: cycle after reset, state=IDLE and all outputs at reset values.
//    No pulse is emitted.
//  - Unused state encodings recover to IDLE.
// CONFIGURATION
//  - GAME_STATS_BCD_SCORE_EN defined: score and final_score are 2-digit packed BCD.
//    Increment carries at 9 (8'h09 -> 8'h10) and saturates at 8'h99.
//  - GAME_STATS_BCD_SCORE_EN undefined: plain binary, saturating at 8'hFF.
//  - Pulse timing and all other behaviour are identical in both builds.
// TESTING
//  Use parameters HIT_COOLDOWN=4, GO_STEP_CYCLES=3, GO_STEPS=4, START_HEALTH=3.
//  1. Reset, then start pulse -> state=1, score=0, health=3. kill,hit ignored in IDLE.
//  2. 3 kills 2 cycles apart -> score 1,2,3. score_pulse high 1 cycle after each kill.
//  3. Hit, then another hit 2 cycles later -> health=2 and one health_pulse; second
//     hit dropped. Hit 4 cycles after the first -> health=1.
//  4. Kill and hit in the same cycle with health=1 -> score+1 and health=0, both pulses
//     fire, state=2, final_score=new score.
//     Then exactly 4 gameover_pulses, 3 cycles apart, then state=3, final_valid=1.
//  5. Binary build: 256 kills -> score=8'hFF, 256th still pulses.
//     BCD build: 10 kills -> 8'h10. 100 kills -> 8'h99.
//  6. Reset asserted during PLAY, and again during OVER between pulses -> next cycle
//     state=0, score=0, health=3, no pulses. Start from DONE restarts with final_score kept.

Source files
------------

// File: rtl/game_stats_ctrl.sv
// Gameplay statistics controller: turns kill/hit/start events into score, health and game-over
// state for the display stage. Define GAME_STATS_BCD_SCORE_EN for 2-digit packed BCD scoring.
module game_stats_ctrl #(
  parameter logic [3:0]  START_HEALTH   = 4'hF,
  parameter int unsigned HIT_COOLDOWN   = 25_000_000,
  parameter int unsigned GO_STEP_CYCLES = 12_500_000,
  parameter int unsigned GO_STEPS       = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_enemy_killed,
  input  logic       i_player_hit,
  output logic [7:0] o_score,
  output logic [3:0] o_health,
  output logic       o_score_pulse,
  output logic       o_health_pulse,
  output logic       o_gameover_pulse,
  output logic [7:0] o_final_score,
  output logic       o_final_valid,
  output logic [1:0] o_state
);

  localparam int unsigned CdW = (HIT_COOLDOWN > 1) ? $clog2(HIT_COOLDOWN) : 1;
  localparam int unsigned TmW = (GO_STEP_CYCLES > 1) ? $clog2(GO_STEP_CYCLES) : 1;

  localparam logic [CdW-1:0] CdLoad   = CdW'(HIT_COOLDOWN - 1);
  localparam logic [TmW-1:0] TmLast   = TmW'(GO_STEP_CYCLES - 1);
  localparam logic [3:0]     StepLast = 4'(GO_STEPS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e         r_state, w_state_next;
  logic [7:0]     r_score, w_score_next;
  logic [3:0]     r_health, w_health_next;
  logic           r_score_pulse, w_score_pulse_next;
  logic           r_health_pulse, w_health_pulse_next;
  logic           r_gameover_pulse, w_gameover_pulse_next;
  logic [7:0]     r_final_score, w_final_score_next;
  logic           r_final_valid, w_final_valid_next;
  logic [CdW-1:0] r_cooldown, w_cooldown_next;
  logic [TmW-1:0] r_timer, w_timer_next;
  logic [3:0]     r_step, w_step_next;

  logic           w_hit_ok;

  function automatic logic [7:0] f_score_inc(input logic [7:0] s);
`ifdef GAME_STATS_BCD_SCORE_EN
    if (s == 8'h99) begin
      return s;
    end else if (s[3:0] >= 4'h9) begin
      return {s[7:4] + 4'h1, 4'h0};
    end else begin
      return s + 8'h1;
    end
`else
    return (s == 8'hFF) ? s : s + 8'h1;
`endif
  endfunction

  assign w_hit_ok = i_player_hit && (r_cooldown == '0) && (r_health != 4'h0);

  always_comb begin
    w_state_next          = r_state;
    w_score_next          = r_score;
    w_health_next         = r_health;
    w_score_pulse_next    = 1'b0;
    w_health_pulse_next   = 1'b0;
    w_gameover_pulse_next = 1'b0;
    w_final_score_next    = r_final_score;
    w_final_valid_next    = r_final_valid;
    w_cooldown_next       = r_cooldown;
    w_timer_next          = r_timer;
    w_step_next           = r_step;

    case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_next       = StPlay;
          w_score_next       = 8'h00;
          w_health_next      = START_HEALTH;
          w_cooldown_next    = '0;
          w_final_valid_next = 1'b0;
        end
      end
      StPlay: begin
        if (i_enemy_killed) begin
          w_score_next       = f_score_inc(r_score);
          w_score_pulse_next = 1'b1;
        end
        if (w_hit_ok) begin
          w_health_next       = r_health - 4'h1;
          w_health_pulse_next = 1'b1;
          w_cooldown_next     = CdLoad;
          // Final score includes any kill counted in this same cycle.
          if (r_health == 4'h1) begin
            w_state_next       = StOver;
            w_final_score_next = w_score_next;
            w_timer_next       = '0;
            w_step_next        = 4'h0;
          end
        end else if (r_cooldown != '0) begin
          w_cooldown_next = r_cooldown - 1'b1;
        end
      end
      StOver: begin
        if (r_timer == TmLast) begin
          w_timer_next          = '0;
          w_gameover_pulse_next = 1'b1;
          w_step_next           = r_step + 4'h1;
          if (r_step == StepLast) begin
            w_state_next       = StDone;
            w_final_valid_next = 1'b1;
          end
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= StIdle;
      r_score          <= 8'h00;
      r_health         <= START_HEALTH;
      r_score_pulse    <= 1'b0;
      r_health_pulse   <= 1'b0;
      r_gameover_pulse <= 1'b0;
      r_final_score    <= 8'h00;
      r_final_valid    <= 1'b0;
      r_cooldown       <= '0;
      r_timer          <= '0;
      r_step           <= 4'h0;
    end else begin
      r_state          <= w_state_next;
      r_score          <= w_score_next;
      r_health         <= w_health_next;
      r_score_pulse    <= w_score_pulse_next;
      r_health_pulse   <= w_health_pulse_next;
      r_gameover_pulse <= w_gameover_pulse_next;
      r_final_score    <= w_final_score_next;
      r_final_valid    <= w_final_valid_next;
      r_cooldown       <= w_cooldown_next;
      r_timer          <= w_timer_next;
      r_step           <= w_step_next;
    end
  end

  assign o_score          = r_score;
  assign o_health         = r_health;
  assign o_score_pulse    = r_score_pulse;
  assign o_health_pulse   = r_health_pulse;
  assign o_gameover_pulse = r_gameover_pulse;
  assign o_final_score    = r_final_score;
  assign o_final_valid    = r_final_valid;
  assign o_state          = r_state;

endmodule

// File: tb/tb_game_stats_ctrl.sv
// Scoreboard bench for game_stats_ctrl: a behavioural model queues expected outputs per cycle,
// each test task pops and compares them against the DUT.
module tb_game_stats_ctrl;

  localparam logic [3:0] SH = 4'd3;
  localparam int HC = 4;
  localparam int GC = 3;
  localparam int GS = 4;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] sc;
    logic [3:0] hl;
    logic       sp;
    logic       hp;
    logic       gp;
    logic [7:0] fs;
    logic       fv;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, kill = 1'b0, hit = 1'b0;
  logic [7:0] score, final_score;
  logic [3:0] health;
  logic       score_pulse, health_pulse, gameover_pulse, final_valid;
  logic [1:0] state;

  int   tests = 0;
  int   fails = 0;
  obs_t m;
  int   m_cd, m_tm, m_step;
  obs_t q[$];

  game_stats_ctrl #(
    .START_HEALTH  (SH),
    .HIT_COOLDOWN  (HC),
    .GO_STEP_CYCLES(GC),
    .GO_STEPS      (GS)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .i_enemy_killed  (kill),
    .i_player_hit    (hit),
    .o_score         (score),
    .o_health        (health),
    .o_score_pulse   (score_pulse),
    .o_health_pulse  (health_pulse),
    .o_gameover_pulse(gameover_pulse),
    .o_final_score   (final_score),
    .o_final_valid   (final_valid),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  function automatic obs_t obs();
    obs_t o;
    o.st = state; o.sc = score; o.hl = health; o.sp = score_pulse; o.hp = health_pulse;
    o.gp = gameover_pulse; o.fs = final_score; o.fv = final_valid;
    return o;
  endfunction

  function automatic logic [7:0] model_inc(input logic [7:0] s);
`ifdef GAME_STATS_BCD_SCORE_EN
    int v;
    v = int'(s[7:4]) * 10 + int'(s[3:0]);
    if (v < 99) v++;
    return {4'(v / 10), 4'(v % 10)};
`else
    int v;
    v = int'(s) + 1;
    return (v > 255) ? 8'hFF : 8'(v);
`endif
  endfunction

  task automatic model_step(input logic s, input logic k, input logic h, input logic r);
    obs_t n;
    n = m; n.sp = 1'b0; n.hp = 1'b0; n.gp = 1'b0;
    if (r) begin
      n.st = 2'd0; n.sc = 8'h00; n.hl = SH; n.fs = 8'h00; n.fv = 1'b0;
      m_cd = 0; m_tm = 0; m_step = 0;
    end else if (m.st == 2'd0 || m.st == 2'd3) begin
      if (s) begin
        n.st = 2'd1; n.sc = 8'h00; n.hl = SH; n.fv = 1'b0; m_cd = 0;
      end
    end else if (m.st == 2'd1) begin
      if (k) begin
        n.sc = model_inc(m.sc); n.sp = 1'b1;
      end
      if (h && m_cd == 0) begin
        n.hl = m.hl - 4'd1; n.hp = 1'b1; m_cd = HC - 1;
        if (n.hl == 4'd0) begin
          n.st = 2'd2; n.fs = n.sc; m_tm = 0; m_step = 0;
        end
      end else if (m_cd != 0) begin
        m_cd--;
      end
    end else begin
      if (m_tm == GC - 1) begin
        m_tm = 0; n.gp = 1'b1; m_step++;
        if (m_step == GS) begin
          n.st = 2'd3; n.fv = 1'b1;
        end
      end else begin
        m_tm++;
      end
    end
    m = n;
  endtask

  task automatic cycle(input logic s, input logic k, input logic h, input logic r);
    reset = r; start = s; kill = k; hit = h;
    model_step(s, k, h, r);
    q.push_back(m);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; kill = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b1);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL reset cyc%0d got=%h exp=%h", i, got, exp);
      end
    end
    tests++;
    if (state !== 2'd0 || health !== 4'd3 || score !== 8'h00) begin
      fails++; $display("FAIL reset_values got st=%0d hl=%0d sc=%h exp st=0 hl=3 sc=00",
                        state, health, score);
    end
  endtask

  task automatic test_idle_ignore();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, i[0], 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL idle_ignore cyc%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_start();
    obs_t got, exp;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    exp = q.pop_front(); got = obs(); tests++;
    if (got !== exp) begin
      fails++; $display("FAIL start got=%h exp=%h", got, exp);
    end
    tests++;
    if (state !== 2'd1 || score !== 8'h00 || health !== 4'd3) begin
      fails++; $display("FAIL start_values got st=%0d sc=%h hl=%0d exp st=1 sc=00 hl=3",
                        state, score, health);
    end
  endtask

  task automatic test_kills();
    obs_t got, exp;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, (i % 2) == 0, 1'b0, 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL kills cyc%0d got=%h exp=%h", i, got, exp);
      end
    end
    tests++;
    if (score !== 8'h03) begin
      fails++; $display("FAIL kills_total got=%h exp=03", score);
    end
  endtask

  task automatic test_hits();
    obs_t got, exp;
    int   hp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, (i == 0 || i == 2 || i == 4), 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL hits cyc%0d got=%h exp=%h", i, got, exp);
      end
      if (i < 4) hp_cnt += int'(got.hp);
    end
    tests++;
    if (hp_cnt != 1 || health !== 4'd1) begin
      fails++; $display("FAIL hits_cooldown got pulses=%0d hl=%0d exp pulses=1 hl=1",
                        hp_cnt, health);
    end
  endtask

  task automatic test_gameover();
    obs_t got, exp;
    int   gp_cnt = 0;
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    exp = q.pop_front(); got = obs(); tests++;
    if (got !== exp) begin
      fails++; $display("FAIL kill_hit_same got=%h exp=%h", got, exp);
    end
    tests++;
    if (state !== 2'd2 || score !== 8'h04 || health !== 4'd0 || final_score !== 8'h04 ||
        score_pulse !== 1'b1 || health_pulse !== 1'b1) begin
      fails++; $display("FAIL enter_over got st=%0d sc=%h hl=%0d fs=%h exp st=2 sc=04 hl=0 fs=04",
                        state, score, health, final_score);
    end
    // start, kill and hit during OVER must all be ignored
    for (int i = 0; i < 14; i++) begin
      cycle(i < 5, i[0], i[1], 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL over cyc%0d got=%h exp=%h", i, got, exp);
      end
      gp_cnt += int'(got.gp);
    end
    tests++;
    if (gp_cnt != 4 || state !== 2'd3 || final_valid !== 1'b1) begin
      fails++; $display("FAIL over_done got pulses=%0d st=%0d fv=%b exp pulses=4 st=3 fv=1",
                        gp_cnt, state, final_valid);
    end
  endtask

  task automatic test_restart();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      cycle(i == 1, 1'b0, 1'b0, 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL restart cyc%0d got=%h exp=%h", i, got, exp);
      end
    end
    tests++;
    if (state !== 2'd1 || final_score !== 8'h04 || final_valid !== 1'b0 || health !== 4'd3) begin
      fails++; $display("FAIL restart_values got st=%0d fs=%h fv=%b hl=%0d exp st=1 fs=04 fv=0 hl=3",
                        state, final_score, final_valid, health);
    end
  endtask

  task automatic test_back_to_back_sat();
    obs_t got, exp;
`ifdef GAME_STATS_BCD_SCORE_EN
    localparam int N = 100;
`else
    localparam int N = 256;
`endif
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL sat cyc%0d got=%h exp=%h", i, got, exp);
      end
`ifdef GAME_STATS_BCD_SCORE_EN
      if (i == 9) begin
        tests++;
        if (score !== 8'h10) begin
          fails++; $display("FAIL bcd_carry got=%h exp=10", score);
        end
      end
`endif
    end
    tests++;
`ifdef GAME_STATS_BCD_SCORE_EN
    if (score !== 8'h99 || score_pulse !== 1'b1) begin
      fails++; $display("FAIL sat_final got sc=%h sp=%b exp sc=99 sp=1", score, score_pulse);
    end
`else
    if (score !== 8'hFF || score_pulse !== 1'b1) begin
      fails++; $display("FAIL sat_final got sc=%h sp=%b exp sc=ff sp=1", score, score_pulse);
    end
`endif
  endtask

  task automatic test_reset_midgame();
    obs_t got, exp;
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    exp = q.pop_front(); got = obs(); tests++;
    if (got !== exp || state !== 2'd0 || score_pulse !== 1'b0 || health_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_play got=%h exp=%h", got, exp);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    void'(q.pop_front());
    // three hits spaced past the cooldown, then land between the first and second pulse
    for (int i = 0; i < 13; i++) begin
      cycle(1'b0, 1'b0, (i % 4) == 0 && i <= 8, 1'b0);
      exp = q.pop_front(); got = obs(); tests++;
      if (got !== exp) begin
        fails++; $display("FAIL reset_over_setup cyc%0d got=%h exp=%h", i, got, exp);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    exp = q.pop_front(); got = obs(); tests++;
    if (got !== exp || state !== 2'd0 || score !== 8'h00 || health !== 4'd3 ||
        gameover_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_over got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_start();
    test_kills();
    test_hits();
    test_gameover();
    test_restart();
    test_back_to_back_sat();
    test_reset_midgame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
